uart_recv_frame64: RTL and testbench
====================================

# uart_recv_frame64

UART receiver that deserialises 8-N-1 bytes from a single RX pin and assembles eight consecutive bytes into one 64-bit word with a one-cycle completion strobe. It is the receive-side counterpart of the 64-bit UART sender feeding JD[2]. It sits beside the cipher datapath so that externally supplied 64-bit blocks (ciphertext or keys) can be captured from a host link.

## Interface

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- UART_BPS, 115200, baud rate; bit period BPS_CNT = CLK_FREQ/UART_BPS (868 at defaults)
- TIMEOUT_BITS, 20, inter-byte idle limit in bit periods (used only with the timeout feature)

Ports:
- CLK100MHZ  input  1  system clock; reset CPU_RESETN, asynchronous, active-low; clock CLK100MHZ
- CPU_RESETN  input  1  asynchronous active-low reset
- uart_rxd  input  1  serial line, idle high, asynchronous to clock
- uart_done  output  1  one-cycle pulse: uart_data holds a new complete word
- uart_data  output  64  last completed word; first received byte in [63:56], eighth in [7:0]
- uart_frame_err  output  1  one-cycle pulse on bad stop bit
- uart_busy  output  1  high from validated start-bit edge until stop-bit sample

## Operation

- uart_rxd passes through a 2-FF synchroniser plus one extra register; a falling edge is sync2 low and sync3 high.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on falling edge -> START, clear the baud counter.
- START: at count BPS_CNT/2 − 1 sample the line; if low -> DATA (counter reset); if high (glitch) -> IDLE, no output.
- DATA: sample at each BPS_CNT boundary; 8 bits, LSB first, shifted into the byte register; after bit 7 -> STOP.
- STOP: sample at the next BPS_CNT boundary. If high: store the byte at slot byte_cnt (0..7) of the 64-bit shift/assembly register, then increment byte_cnt. If low: pulse uart_frame_err, discard the byte, clear byte_cnt to 0. Both cases -> IDLE.
- When byte_cnt wraps 7 -> 0 on a good stop bit: copy the assembled word to uart_data and pulse uart_done.
- uart_data holds its value until the next completed word; partial frames never modify it.
- byte_cnt is 3 bits; baud counter is wide enough for BPS_CNT − 1, i.e. $clog2(BPS_CNT) bits.

## Timing

- Reset values: uart_done 0, uart_data 64'h0, uart_frame_err 0, uart_busy 0; FSM in IDLE; byte_cnt 0; synchroniser registers 1.
- Edge detection takes 3 cycles after the line falls. The start bit is checked BPS_CNT/2 cycles later. Data bit n is sampled (n+1)·BPS_CNT cycles after that check, and the stop bit 9·BPS_CNT cycles after it.
- uart_done and uart_frame_err assert on the clock after the stop sample, for exactly 1 cycle. uart_data is valid on the same cycle as uart_done.
- The FSM returns to IDLE half a bit before the nominal frame end, so back-to-back frames with no idle gap are received.
- The line is not checked during DATA; a falling edge seen mid-byte is ignored.
- Reset mid-frame: all state clears immediately and any partial word is lost.

## Configuration

- UART_RECV_TIMEOUT_EN defined: an idle counter runs in IDLE whenever byte_cnt ≠ 0. When it reaches TIMEOUT_BITS·BPS_CNT cycles, byte_cnt clears to 0 and no pulse is issued. The counter restarts at every falling edge. This resynchronises word alignment after a dropped byte.
- Macro undefined: no idle counter. A partial word persists indefinitely until 8 bytes arrive or a frame error occurs.

## Test plan

- Send bytes 01 23 45 67 89 AB CD EF back-to-back at 115200 -> one uart_done pulse; uart_data = 64'h0123456789ABCDEF; uart_frame_err never asserts.
- Line low for 100 cycles then high -> FSM returns to IDLE from START; no busy beyond that window; byte_cnt unchanged; no pulses.
- 8-byte frame with byte 3 stop bit forced 0, then valid 11 22 33 44 55 66 77 88 -> one uart_frame_err pulse; then uart_done with 64'h1122334455667788.
- Send AA BB CC, idle 30 bit periods, then send 8 bytes 00..07. With UART_RECV_TIMEOUT_EN: uart_data = 64'h0001020304050607. Without it: 64'hAABBCC0001020304 on the 5th new byte.
- Assert CPU_RESETN low during bit 4 of the 6th byte, release, then send 8 bytes F0..F7 -> outputs zero during reset; then uart_data = 64'hF0F1F2F3F4F5F6F7.
- Baud ±2% skew (BPS_CNT·1.02 stimulus) on 8 bytes 5A -> uart_data = 64'h5A5A5A5A5A5A5A5A with no frame error.

Source files
------------

// File: rtl/uart_recv_frame64.sv
// rtl/uart_recv_frame64.sv - 8-N-1 UART receiver assembling eight bytes into one 64-bit word
// Optional inter-byte idle timeout: define UART_RECV_TIMEOUT_EN.
`timescale 1ns/1ps
module uart_recv_frame64 #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int UART_BPS     = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        uart_rxd,
    output logic        uart_done,
    output logic [63:0] uart_data,
    output logic        uart_frame_err,
    output logic        uart_busy
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = $clog2(BPS_CNT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BPS_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BPS_CNT - 1);

`ifdef UART_RECV_TIMEOUT_EN
    localparam int IDLE_LIMIT = TIMEOUT_BITS * BPS_CNT;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);
    logic [IDLE_W-1:0] r_idle_cnt;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic [CNT_W-1:0] r_baud;
    logic [2:0]       r_bit_idx;
    logic [2:0]       r_byte_cnt;
    logic [7:0]       r_byte;
    logic [63:0]      r_word;
    logic             w_fall;

    // Two flops for metastability, the third only for edge detection.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_fall = ~r_sync2 & r_sync3;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state        <= S_IDLE;
            r_baud         <= '0;
            r_bit_idx      <= '0;
            r_byte_cnt     <= '0;
            r_byte         <= '0;
            r_word         <= '0;
            uart_done      <= 1'b0;
            uart_data      <= '0;
            uart_frame_err <= 1'b0;
            uart_busy      <= 1'b0;
`ifdef UART_RECV_TIMEOUT_EN
            r_idle_cnt     <= '0;
`endif
        end else begin
            uart_done      <= 1'b0;
            uart_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state   <= S_START;
                        r_baud    <= '0;
                        uart_busy <= 1'b1;
                    end
`ifdef UART_RECV_TIMEOUT_EN
                    // A stalled partial word is dropped so the next byte starts a fresh word.
                    if (w_fall) begin
                        r_idle_cnt <= '0;
                    end else if (r_byte_cnt != 3'd0) begin
                        if (r_idle_cnt == IDLE_LAST) begin
                            r_idle_cnt <= '0;
                            r_byte_cnt <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
`endif
                end
                S_START: begin
                    if (r_baud == HALF_LAST) begin
                        r_baud <= '0;
                        if (!r_sync2) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state   <= S_IDLE;
                            uart_busy <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_baud == BIT_LAST) begin
                        r_baud    <= '0;
                        r_byte    <= {r_sync2, r_byte[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_baud == BIT_LAST) begin
                        r_baud    <= '0;
                        r_state   <= S_IDLE;
                        uart_busy <= 1'b0;
                        if (r_sync2) begin
                            // First byte shifts up to [63:56] by the time the eighth lands.
                            r_word     <= {r_word[55:0], r_byte};
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            if (r_byte_cnt == 3'd7) begin
                                uart_data <= {r_word[55:0], r_byte};
                                uart_done <= 1'b1;
                            end
                        end else begin
                            uart_frame_err <= 1'b1;
                            r_byte_cnt     <= '0;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    uart_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv_frame64.sv
// tb/tb_uart_recv_frame64.sv - directed self-checking bench for uart_recv_frame64
`timescale 1ns/1ps
module tb_uart_recv_frame64;

    localparam int CLK_FREQ = 5_000_000;
    localparam int UART_BPS = 100_000;
    localparam int BPS      = CLK_FREQ / UART_BPS;

`ifdef UART_RECV_TIMEOUT_EN
    localparam logic [63:0] EXP_TIMEOUT = 64'h0001020304050607;
`else
    localparam logic [63:0] EXP_TIMEOUT = 64'hAABBCC0001020304;
`endif

    logic        CLK100MHZ = 1'b0;
    logic        CPU_RESETN = 1'b0;
    logic        uart_rxd = 1'b1;
    logic        uart_done;
    logic [63:0] uart_data;
    logic        uart_frame_err;
    logic        uart_busy;

    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    int          ferr_cnt = 0;
    int          busy_cnt = 0;
    int          d0, f0, b0;
    logic        busy_mid;
    logic [63:0] last_data = '0;
    logic [63:0] held;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    uart_recv_frame64 #(
        .CLK_FREQ(CLK_FREQ),
        .UART_BPS(UART_BPS),
        .TIMEOUT_BITS(20)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .CPU_RESETN(CPU_RESETN),
        .uart_rxd(uart_rxd),
        .uart_done(uart_done),
        .uart_data(uart_data),
        .uart_frame_err(uart_frame_err),
        .uart_busy(uart_busy)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(negedge CLK100MHZ) begin
        if (uart_done) begin
            done_cnt++;
            last_data = uart_data;
        end
        if (uart_frame_err) ferr_cnt++;
        if (uart_busy) busy_cnt++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK100MHZ);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v, input int per);
        uart_rxd = 1'b0;
        wait_cycles(per);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            wait_cycles(per / 2);
            if (i == 4) busy_mid = uart_busy;
            wait_cycles(per - per / 2);
        end
        uart_rxd = stop_v;
        wait_cycles(per);
        uart_rxd = 1'b1;
    endtask

    initial begin
        wait_cycles(3);
        check("rst_done", uart_done, 1'b0);
        check("rst_data", uart_data, 64'h0);
        check("rst_ferr", uart_frame_err, 1'b0);
        check("rst_busy", uart_busy, 1'b0);
        CPU_RESETN = 1'b1;
        wait_cycles(2 * BPS);

        d0 = done_cnt; f0 = ferr_cnt; busy_mid = 1'b0;
        send_byte(8'h01, 1'b1, BPS); send_byte(8'h23, 1'b1, BPS);
        send_byte(8'h45, 1'b1, BPS); send_byte(8'h67, 1'b1, BPS);
        send_byte(8'h89, 1'b1, BPS); send_byte(8'hAB, 1'b1, BPS);
        send_byte(8'hCD, 1'b1, BPS); send_byte(8'hEF, 1'b1, BPS);
        wait_cycles(BPS);
        check("w1_done_cnt", done_cnt - d0, 1);
        check("w1_data", last_data, 64'h0123456789ABCDEF);
        check("w1_held", uart_data, 64'h0123456789ABCDEF);
        check("w1_ferr_cnt", ferr_cnt - f0, 0);
        check("w1_busy_mid", busy_mid, 1'b1);

        d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        uart_rxd = 1'b0;
        wait_cycles(10);
        uart_rxd = 1'b1;
        wait_cycles(3 * BPS);
        check("gl_busy_cycles", busy_cnt - b0, BPS / 2);
        check("gl_done_cnt", done_cnt - d0, 0);
        check("gl_ferr_cnt", ferr_cnt - f0, 0);
        check("gl_busy_end", uart_busy, 1'b0);

        d0 = done_cnt; f0 = ferr_cnt;
        send_byte(8'hA0, 1'b1, BPS); send_byte(8'hA1, 1'b1, BPS);
        send_byte(8'hA2, 1'b1, BPS); send_byte(8'hA3, 1'b0, BPS);
        wait_cycles(2 * BPS);
        check("fe_ferr_cnt", ferr_cnt - f0, 1);
        check("fe_data_kept", uart_data, 64'h0123456789ABCDEF);
        send_byte(8'h11, 1'b1, BPS); send_byte(8'h22, 1'b1, BPS);
        send_byte(8'h33, 1'b1, BPS); send_byte(8'h44, 1'b1, BPS);
        send_byte(8'h55, 1'b1, BPS); send_byte(8'h66, 1'b1, BPS);
        send_byte(8'h77, 1'b1, BPS); send_byte(8'h88, 1'b1, BPS);
        wait_cycles(BPS);
        check("fe_done_cnt", done_cnt - d0, 1);
        check("fe_data", last_data, 64'h1122334455667788);
        check("fe_ferr_total", ferr_cnt - f0, 1);

        d0 = done_cnt;
        send_byte(8'hAA, 1'b1, BPS); send_byte(8'hBB, 1'b1, BPS);
        send_byte(8'hCC, 1'b1, BPS);
        wait_cycles(30 * BPS);
        for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1, BPS);
        wait_cycles(BPS);
        check("to_done_cnt", done_cnt - d0, 1);
        check("to_data", last_data, EXP_TIMEOUT);

        for (int i = 0; i < 5; i++) send_byte(8'h3C, 1'b1, BPS);
        uart_rxd = 1'b0;
        wait_cycles(BPS);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = i[0];
            wait_cycles(BPS);
        end
        uart_rxd = 1'b1;
        wait_cycles(BPS / 2);
        CPU_RESETN = 1'b0;
        wait_cycles(2);
        check("mr_done", uart_done, 1'b0);
        check("mr_data", uart_data, 64'h0);
        check("mr_ferr", uart_frame_err, 1'b0);
        check("mr_busy", uart_busy, 1'b0);
        wait_cycles(2);
        CPU_RESETN = 1'b1;
        wait_cycles(4 * BPS);
        d0 = done_cnt; f0 = ferr_cnt;
        for (int i = 0; i < 8; i++) send_byte(8'hF0 + 8'(i), 1'b1, BPS);
        wait_cycles(BPS);
        check("mr_done_cnt", done_cnt - d0, 1);
        check("mr_word", last_data, 64'hF0F1F2F3F4F5F6F7);

        d0 = done_cnt; f0 = ferr_cnt;
        for (int i = 0; i < 8; i++) send_byte(8'h5A, 1'b1, BPS + 1);
        wait_cycles(BPS);
        check("sk_slow_data", last_data, 64'h5A5A5A5A5A5A5A5A);
        check("sk_slow_ferr", ferr_cnt - f0, 0);
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) send_byte(8'hA5, 1'b1, BPS - 1);
        wait_cycles(BPS);
        check("sk_fast_done_cnt", done_cnt - d0, 1);
        check("sk_fast_data", last_data, 64'hA5A5A5A5A5A5A5A5);
        check("sk_fast_ferr", ferr_cnt - f0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
